store_buffer: RTL and testbench
===============================

# store_buffer

Posted-write store buffer between the single-cycle datapath's memory port (`aluout`, `writedata`, `readdata`) and a handshaked data memory. Stores retire from the datapath in one cycle into a small FIFO and drain to memory in the background. Loads are served by forwarding from the youngest matching buffered store, or by a priority memory read. `stall` freezes the datapath/PC while the buffer cannot complete the current access.

## Interface
- `DEPTH`, 4: buffer entries; power of two, at least 2.
- `AW`, 32: byte address width. Matching uses `addr[AW-1:2]`.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `memwrite`  in  1  datapath store request this cycle.
- `memread`  in  1  datapath load request this cycle.
- `aluout`  in  AW  byte address of the access.
- `writedata`  in  32  store data.
- `readdata`  out  32  load result to the writeback mux.
- `stall`  out  1  datapath must hold its current instruction.
- `mem_req`  out  1  memory transaction valid.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_addr`  out  AW  word-aligned address, `[1:0]` = 0.
- `mem_wdata`  out  32  write data.
- `mem_ack`  in  1  memory accepts/completes; a transfer completes on a rising edge where `mem_req & mem_ack`.
- `mem_rdata`  in  32  read data, valid while `mem_ack` is high on a read.

## Operation
- FSM states: IDLE, DRAIN (write in flight), LOAD (read in flight).
- **IDLE**
  - Go to LOAD on an unforwarded load (load miss) with no store issued this cycle.
  - Otherwise go to DRAIN if the buffer is non-empty after this cycle's enqueue.
- **DRAIN**
  - Drives the head entry with `mem_we=1`.
  - On ack: pop the head.
  - Then go to LOAD if a load miss is pending; else stay in DRAIN if entries remain; else go to IDLE.
- **LOAD**
  - Drives `mem_we=0` with the load address.
  - On ack: go to DRAIN if the buffer is non-empty, else IDLE.
  - A load miss pends while a write is in flight. Loads take priority over further drains.
- **Store accept**
  - `accept = memwrite & (!full | drain_done)`, where `drain_done = DRAIN & mem_ack`.
  - Full with a simultaneous pop accepts the store.
- **Load hit**
  - Hit when any valid entry's word address equals `aluout[AW-1:2]`; the youngest matching entry wins.
  - `readdata` takes that entry's data combinationally; `stall=0`.
- **Load miss**
  - `stall=1` until the LOAD-state ack cycle.
  - In that cycle `readdata = mem_rdata` and `stall=0`.
- `readdata = 0` when no load is being answered.
- `memread & memwrite` together is treated as a store; the read is ignored.
- `stall = (memwrite & !accept) | (memread & !hit & !(LOAD & mem_ack))`.
- The datapath holds `memread`, `memwrite`, `aluout` and `writedata` stable while `stall` is high.

## Timing
- Reset values (asynchronous): buffer empty, pointers and count 0, state IDLE, `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `stall=0`, `readdata=0`.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are registered. They stay stable from assertion until the ack edge.
- `mem_req` deasserts the cycle after ack unless the next transfer starts back-to-back.
- **Store latency:** accepted at the edge ending the request cycle. The first `mem_req` appears the following cycle (from IDLE).
- **Load hit:** zero added cycles.
- **Load miss from IDLE:** `mem_req` rises the next cycle. The stall lasts 1 + ack-wait cycles. With `mem_ack` tied high, a miss costs one stall cycle.
- **Load miss during DRAIN:** waits for the write ack, then LOAD.
- **Wrap-around:** head and tail are `log2(DEPTH)`-bit and wrap modulo DEPTH. `count` is `log2(DEPTH)+1` bits.
- **Reset mid-transaction:** all state, including in-flight requests, is abandoned immediately. No write is retried.

## Structure
- Shared package `mips_pkg`:
  - `sb_state_t` enum (IDLE, DRAIN, LOAD);
  - word-address slice constants.
- One sub-module, `store_queue`:
  - DEPTH-entry address/data FIFO with push/pop, full/empty and count;
  - exposes the valid vector and entry arrays so the top can do the youngest-match search.
- The FSM, forwarding priority encoder and memory-port registers live in the top.

## Test plan
1. Reset mid-DRAIN (`mem_req=1`, ack held low) → next cycle `mem_req=0`, count 0, `stall=0`; a subsequent load of that address misses.
2. Store `0xDEADBEEF` to `0x100`, load `0x100` next cycle with ack held low → `readdata=0xDEADBEEF`, `stall=0`, no read issued.
3. Stores to `0x100` (`0x11`) then `0x100` (`0x22`), load `0x103` → `readdata=0x22` (youngest wins, byte offset ignored).
4. Fill 4 entries with ack low; 5th store → `stall=1`. Raise ack for 1 cycle → 5th store accepted that edge, count stays 4.
5. Load miss `0x200` while the write to `0x100` is in flight; ack after 2 cycles, then `mem_rdata=0x1234` → write completes first, read follows, `readdata=0x1234` on the ack cycle, then remaining drains resume.
6. `mem_ack` tied high, 8 alternating stores and loads to distinct addresses → all stores reach memory in order, each load miss stalls exactly 1 cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the store buffer
package mips_pkg;

  typedef enum logic [1:0] {
    SB_IDLE  = 2'd0,
    SB_DRAIN = 2'd1,
    SB_LOAD  = 2'd2
  } sb_state_t;

  // Byte-offset bits dropped when comparing word addresses
  localparam int WORD_LSB = 2;

endpackage

// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - handshaked data-memory port between store buffer and memory
interface store_buffer_if #(
  parameter int AW = 32
) ();

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ack;
  logic [31:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/store_queue.sv
// rtl/store_queue.sv - DEPTH-entry word-address/data FIFO exposing its entries for forwarding
module store_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int WAW  = AW - WORD_LSB
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push,
  input  logic [WAW-1:0]                   push_addr,
  input  logic [31:0]                      push_data,
  input  logic                             pop,
  output logic                             full,
  output logic                             empty,
  output logic [PW:0]                      count,
  output logic [PW-1:0]                    head,
  output logic [DEPTH-1:0]                 valid,
  output logic [DEPTH-1:0][WAW-1:0]        entry_addr,
  output logic [DEPTH-1:0][31:0]           entry_data
);

  logic [PW-1:0] tail;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

  // When full with simultaneous push and pop, head == tail: the later valid set wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      valid      <= '0;
      entry_addr <= '0;
      entry_data <= '0;
    end else begin
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      if (push) begin
        valid[tail]      <= 1'b1;
        entry_addr[tail] <= push_addr;
        entry_data[tail] <= push_data;
        tail             <= tail + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write store buffer with load forwarding and priority memory reads
module store_buffer
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memwrite,
  input  logic              memread,
  input  logic [AW-1:0]     aluout,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              stall,
  store_buffer_if.master    mem
);

  localparam int PW  = $clog2(DEPTH);
  localparam int WAW = AW - WORD_LSB;

  sb_state_t                  state;
  logic                       q_full;
  logic                       q_empty;
  logic [PW:0]                q_count;
  logic [PW-1:0]              q_head;
  logic [DEPTH-1:0]           q_valid;
  logic [DEPTH-1:0][WAW-1:0]  q_addr;
  logic [DEPTH-1:0][31:0]     q_data;

  logic [WAW-1:0] word_addr;
  logic           drain_done;
  logic           load_ack;
  logic           accept;
  logic           load_req;
  logic           load_miss;
  logic           hit;
  logic [31:0]    hit_data;
  logic [PW-1:0]  scan_idx;
  logic [PW:0]    count_next;
  logic [PW:0]    remain;
  logic [PW-1:0]  nh_idx;
  logic [WAW-1:0] nh_addr;
  logic [31:0]    nh_data;
  logic           unused_byte_bits;

  assign word_addr        = aluout[AW-1:WORD_LSB];
  assign unused_byte_bits = ^aluout[WORD_LSB-1:0];
  assign drain_done       = (state == SB_DRAIN) & mem.mem_ack;
  assign load_ack         = (state == SB_LOAD) & mem.mem_ack;
  assign accept           = memwrite & (~q_full | drain_done);
  assign load_req         = memread & ~memwrite;
  assign load_miss        = load_req & ~hit;

  store_queue #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (accept),
    .push_addr  (word_addr),
    .push_data  (writedata),
    .pop        (drain_done),
    .full       (q_full),
    .empty      (q_empty),
    .count      (q_count),
    .head       (q_head),
    .valid      (q_valid),
    .entry_addr (q_addr),
    .entry_data (q_data)
  );

  // Scan oldest to youngest so the youngest matching entry overrides earlier ones
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    scan_idx = q_head;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = q_head + PW'(k);
      if (q_valid[scan_idx] && (q_addr[scan_idx] == word_addr)) begin
        hit      = 1'b1;
        hit_data = q_data[scan_idx];
      end
    end
  end

  // Head entry as it will stand after this cycle's pop and push
  always_comb begin
    count_next = q_count + (PW+1)'(accept) - (PW+1)'(drain_done);
    remain     = q_count - (PW+1)'(drain_done);
    nh_idx     = q_head + PW'(drain_done);
    if (remain == '0) begin
      nh_addr = word_addr;
      nh_data = writedata;
    end else begin
      nh_addr = q_addr[nh_idx];
      nh_data = q_data[nh_idx];
    end
  end

  always_comb begin
    readdata = '0;
    if (load_req) begin
      if (hit)           readdata = hit_data;
      else if (load_ack) readdata = mem.mem_rdata;
    end
  end

  assign stall = (memwrite & ~accept) | (load_miss & ~load_ack);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= SB_IDLE;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      case (state)
        SB_IDLE: begin
          if (load_miss) begin
            state        <= SB_LOAD;
            mem.mem_req  <= 1'b1;
            mem.mem_we   <= 1'b0;
            mem.mem_addr <= {word_addr, 2'b00};
          end else if (count_next != '0) begin
            state         <= SB_DRAIN;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= 1'b1;
            mem.mem_addr  <= {nh_addr, 2'b00};
            mem.mem_wdata <= nh_data;
          end
        end
        SB_DRAIN: begin
          if (mem.mem_ack) begin
            if (load_miss) begin
              state        <= SB_LOAD;
              mem.mem_we   <= 1'b0;
              mem.mem_addr <= {word_addr, 2'b00};
            end else if (count_next != '0) begin
              mem.mem_addr  <= {nh_addr, 2'b00};
              mem.mem_wdata <= nh_data;
            end else begin
              state       <= SB_IDLE;
              mem.mem_req <= 1'b0;
              mem.mem_we  <= 1'b0;
            end
          end
        end
        SB_LOAD: begin
          if (mem.mem_ack) begin
            if (count_next != '0) begin
              state         <= SB_DRAIN;
              mem.mem_we    <= 1'b1;
              mem.mem_addr  <= {nh_addr, 2'b00};
              mem.mem_wdata <= nh_data;
            end else begin
              state       <= SB_IDLE;
              mem.mem_req <= 1'b0;
            end
          end
        end
        default: begin
          state       <= SB_IDLE;
          mem.mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic        memread;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        stall;

  int n_pass  = 0;
  int n_total = 0;

  logic        rec = 1'b0;
  logic [31:0] wa_log[$];
  logic [31:0] wd_log[$];

  store_buffer_if #(.AW(32)) mem_bus ();

  store_buffer #(.DEPTH(4), .AW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .memread   (memread),
    .aluout    (aluout),
    .writedata (writedata),
    .readdata  (readdata),
    .stall     (stall),
    .mem       (mem_bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rec && mem_bus.mem_req && mem_bus.mem_ack && mem_bus.mem_we) begin
      wa_log.push_back(mem_bus.mem_addr);
      wd_log.push_back(mem_bus.mem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    memwrite  = w;
    memread   = r;
    aluout    = a;
    writedata = d;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 32'h0;
    #12;
    chk("rst_req",   32'(mem_bus.mem_req),   32'h0);
    chk("rst_we",    32'(mem_bus.mem_we),    32'h0);
    chk("rst_addr",  mem_bus.mem_addr,       32'h0);
    chk("rst_wdata", mem_bus.mem_wdata,      32'h0);
    chk("rst_stall", 32'(stall),             32'h0);
    chk("rst_rdata", readdata,               32'h0);
    chk("rst_count", 32'(dut.u_queue.count), 32'h0);
    cyc();
    reset = 1'b0;

    // Reset mid-DRAIN
    drive(1'b1, 1'b0, 32'h100, 32'hAAAA5555);
    @(negedge clk);
    chk("t1_st_stall", 32'(stall), 32'h0);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t1_req_up", 32'(mem_bus.mem_req), 32'h1);
    chk("t1_addr",   mem_bus.mem_addr,     32'h100);
    reset = 1'b1;
    #1;
    chk("t1_req_abort", 32'(mem_bus.mem_req),   32'h0);
    chk("t1_count",     32'(dut.u_queue.count), 32'h0);
    cyc();
    reset = 1'b0;
    drive(1'b0, 1'b1, 32'h100, 32'h0);
    @(negedge clk);
    chk("t1_miss_stall", 32'(stall), 32'h1);
    chk("t1_miss_rdata", readdata,   32'h0);
    cyc();
    @(negedge clk);
    chk("t1_ld_req",  32'(mem_bus.mem_req), 32'h1);
    chk("t1_ld_we",   32'(mem_bus.mem_we),  32'h0);
    chk("t1_ld_addr", mem_bus.mem_addr,     32'h100);
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 32'hCAFE0001;
    #1;
    chk("t1_ld_stall", 32'(stall), 32'h0);
    chk("t1_ld_rdata", readdata,   32'hCAFE0001);
    cyc();
    mem_bus.mem_ack = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t1_idle_req", 32'(mem_bus.mem_req), 32'h0);
    cyc();

    // Forward from a just-posted store
    drive(1'b1, 1'b0, 32'h100, 32'hDEADBEEF);
    cyc();
    drive(1'b0, 1'b1, 32'h100, 32'h0);
    @(negedge clk);
    chk("t2_rdata", readdata,             32'hDEADBEEF);
    chk("t2_stall", 32'(stall),           32'h0);
    chk("t2_we",    32'(mem_bus.mem_we),  32'h1);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    mem_bus.mem_ack = 1'b1;
    cyc();
    mem_bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("t2_idle", 32'(mem_bus.mem_req), 32'h0);
    cyc();

    // Youngest match wins, byte offset ignored
    drive(1'b1, 1'b0, 32'h100, 32'h11);
    cyc();
    drive(1'b1, 1'b0, 32'h100, 32'h22);
    cyc();
    drive(1'b0, 1'b1, 32'h103, 32'h0);
    @(negedge clk);
    chk("t3_rdata", readdata,   32'h22);
    chk("t3_stall", 32'(stall), 32'h0);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    mem_bus.mem_ack = 1'b1;
    @(negedge clk);
    chk("t3_wd0", mem_bus.mem_wdata, 32'h11);
    cyc();
    @(negedge clk);
    chk("t3_wd1", mem_bus.mem_wdata, 32'h22);
    cyc();
    mem_bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("t3_idle", 32'(mem_bus.mem_req), 32'h0);
    cyc();

    // Fill to full, then accept on the drain edge
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'h10 + 32'(4 * i), 32'(i + 1));
      cyc();
    end
    drive(1'b1, 1'b0, 32'h20, 32'h5);
    @(negedge clk);
    chk("t4_full_stall", 32'(stall), 32'h1);
    cyc();
    mem_bus.mem_ack = 1'b1;
    @(negedge clk);
    chk("t4_pop_stall", 32'(stall),         32'h0);
    chk("t4_head_addr", mem_bus.mem_addr,   32'h10);
    chk("t4_head_data", mem_bus.mem_wdata,  32'h1);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    mem_bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("t4_count", 32'(dut.u_queue.count), 32'h4);
    cyc();
    mem_bus.mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_dr_addr", mem_bus.mem_addr,  32'h14 + 32'(4 * i));
      chk("t4_dr_data", mem_bus.mem_wdata, 32'(i + 2));
      cyc();
    end
    mem_bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("t4_idle", 32'(mem_bus.mem_req), 32'h0);
    cyc();

    // Load miss waits for the in-flight write, then drains resume
    drive(1'b1, 1'b0, 32'h100, 32'h55);
    cyc();
    drive(1'b1, 1'b0, 32'h104, 32'h66);
    cyc();
    drive(1'b0, 1'b1, 32'h200, 32'h0);
    @(negedge clk);
    chk("t5_l0_stall", 32'(stall),          32'h1);
    chk("t5_l0_we",    32'(mem_bus.mem_we), 32'h1);
    chk("t5_l0_addr",  mem_bus.mem_addr,    32'h100);
    cyc();
    @(negedge clk);
    chk("t5_l1_stall", 32'(stall), 32'h1);
    cyc();
    mem_bus.mem_ack = 1'b1;
    @(negedge clk);
    chk("t5_l2_stall", 32'(stall), 32'h1);
    cyc();
    mem_bus.mem_rdata = 32'h1234;
    @(negedge clk);
    chk("t5_rd_we",    32'(mem_bus.mem_we), 32'h0);
    chk("t5_rd_addr",  mem_bus.mem_addr,    32'h200);
    chk("t5_rd_rdata", readdata,            32'h1234);
    chk("t5_rd_stall", 32'(stall),          32'h0);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    mem_bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("t5_res_req",  32'(mem_bus.mem_req), 32'h1);
    chk("t5_res_we",   32'(mem_bus.mem_we),  32'h1);
    chk("t5_res_addr", mem_bus.mem_addr,     32'h104);
    chk("t5_res_data", mem_bus.mem_wdata,    32'h66);
    cyc();
    mem_bus.mem_ack = 1'b1;
    cyc();
    mem_bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("t5_idle", 32'(mem_bus.mem_req), 32'h0);
    cyc();

    // Ack tied high: alternating stores and load misses
    mem_bus.mem_ack = 1'b1;
    rec = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'h300 + 32'(4 * i), 32'hA0 + 32'(i));
      @(negedge clk);
      chk("t6_st_stall", 32'(stall), 32'h0);
      cyc();
      drive(1'b0, 1'b1, 32'h400 + 32'(4 * i), 32'h0);
      mem_bus.mem_rdata = 32'hB0 + 32'(i);
      @(negedge clk);
      chk("t6_ld_stall1", 32'(stall), 32'h1);
      cyc();
      @(negedge clk);
      chk("t6_ld_stall0", 32'(stall), 32'h0);
      chk("t6_ld_rdata",  readdata,   32'hB0 + 32'(i));
      cyc();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    cyc();
    rec = 1'b0;
    mem_bus.mem_ack = 1'b0;
    chk("t6_nwrites", 32'(wa_log.size()), 32'h4);
    for (int i = 0; i < 4; i++) begin
      if (i < wa_log.size()) begin
        chk("t6_w_addr", wa_log[i], 32'h300 + 32'(4 * i));
        chk("t6_w_data", wd_log[i], 32'hA0 + 32'(i));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
